// File: rtl/fetch_unit_v2.sv
// IF stage + IF/ID register: owns PC, reads imem combinationally, decodes fields, assembles two-word instructions.
// Latency: 1-word instruction on IF/ID 1 cycle after fetch; 2-word instruction 2 cycles after its first word.
// Backpressure: stall freezes PC, FSM, holding regs and IF/ID; redirect (int > jump) overrides stall and squashes.
module fetch_unit_v2 #(
    parameter int          ADDR_W   = 32,
    parameter int          INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               int_en,
    input  logic [ADDR_W-1:0]  int_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_next_pc,
    output logic               if_id_imm_flag,
    output logic [4:0]         if_id_opcode,
    output logic [2:0]         if_id_rs,
    output logic [2:0]         if_id_rd,
    output logic [4:0]         if_id_shmnt,
    output logic [INSTR_W-1:0] if_id_imm
);

    typedef enum logic {S_FETCH, S_IMM} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_inc, pc_nxt, redirect_addr;
    logic [ADDR_W-1:0]  hold_pc;
    logic [INSTR_W-1:0] hold_word;
    logic               redirect;
    logic               hold_ld, issue, bubble;
    logic [INSTR_W-1:0] src_word, src_imm;
    logic [ADDR_W-1:0]  src_pc;

    assign imem_addr     = pc;
    assign pc_inc        = pc + ADDR_W'(PC_STEP);
    assign redirect      = int_en | jump_en;
    assign redirect_addr = int_en ? int_addr : jump_addr;

    // In S_IMM the first word comes from the holding register, the current read is the immediate
    assign src_word = (state == S_IMM) ? hold_word  : imem_rdata;
    assign src_pc   = (state == S_IMM) ? hold_pc    : pc;
    assign src_imm  = (state == S_IMM) ? imem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = S_FETCH;
        end else if (!stall) begin
            case (state)
                S_FETCH: if (imem_rdata[15]) state_nxt = S_IMM;
                S_IMM:   state_nxt = S_FETCH;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_nxt  = pc;
        hold_ld = 1'b0;
        issue   = 1'b0;
        bubble  = 1'b0;
        if (redirect) begin
            pc_nxt = redirect_addr;
            bubble = 1'b1;
        end else if (!stall) begin
            pc_nxt = pc_inc;
            case (state)
                S_FETCH: begin
                    if (imem_rdata[15]) begin
                        hold_ld = 1'b1;
                        bubble  = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
                end
                S_IMM:   issue = 1'b1;
                default: bubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= ADDR_W'(RESET_PC);
            hold_pc        <= '0;
            hold_word      <= '0;
            if_id_valid    <= 1'b0;
            if_id_pc       <= '0;
            if_id_next_pc  <= '0;
            if_id_imm_flag <= 1'b0;
            if_id_opcode   <= '0;
            if_id_rs       <= '0;
            if_id_rd       <= '0;
            if_id_shmnt    <= '0;
            if_id_imm      <= '0;
        end else begin
            pc <= pc_nxt;
            if (hold_ld) begin
                hold_word <= imem_rdata;
                hold_pc   <= pc;
            end
            if (issue) begin
                if_id_valid    <= 1'b1;
                if_id_pc       <= src_pc;
                if_id_next_pc  <= pc_inc;
                if_id_imm_flag <= (state == S_IMM);
                if_id_opcode   <= src_word[15:11];
                if_id_rs       <= src_word[10:8];
                if_id_rd       <= src_word[7:5];
                if_id_shmnt    <= src_word[4:0];
                if_id_imm      <= src_imm;
            end else if (bubble) begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit_v2.sv
// Directed bench for fetch_unit_v2: main 32-bit instance plus a 4-bit-address instance for PC wrap.
module tb_fetch_unit_v2;

    logic        clk = 1'b0;
    logic        rst, stall, jump_en, int_en;
    logic [31:0] jump_addr, int_addr, imem_addr;
    logic [15:0] imem_rdata;
    logic        if_id_valid, if_id_imm_flag;
    logic [31:0] if_id_pc, if_id_next_pc;
    logic [4:0]  if_id_opcode, if_id_shmnt;
    logic [2:0]  if_id_rs, if_id_rd;
    logic [15:0] if_id_imm;

    logic        w_jump_en;
    logic [3:0]  w_jump_addr, w_int_addr, w_imem_addr;
    logic [15:0] w_imem_rdata;
    logic        w_valid, w_imm_flag;
    logic [3:0]  w_pc, w_next_pc;
    logic [4:0]  w_opcode, w_shmnt;
    logic [2:0]  w_rs, w_rd;
    logic [15:0] w_imm;

    logic [15:0] mem  [0:511];
    logic [15:0] mem2 [0:15];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 16'h0000;
    assign w_imem_rdata = mem2[w_imem_addr];

    fetch_unit_v2 dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .int_en(int_en), .int_addr(int_addr),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_next_pc(if_id_next_pc),
        .if_id_imm_flag(if_id_imm_flag), .if_id_opcode(if_id_opcode),
        .if_id_rs(if_id_rs), .if_id_rd(if_id_rd), .if_id_shmnt(if_id_shmnt),
        .if_id_imm(if_id_imm)
    );

    fetch_unit_v2 #(.ADDR_W(4)) dut_w (
        .clk(clk), .rst(rst), .stall(1'b0),
        .jump_en(w_jump_en), .jump_addr(w_jump_addr),
        .int_en(1'b0), .int_addr(w_int_addr),
        .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .if_id_valid(w_valid), .if_id_pc(w_pc), .if_id_next_pc(w_next_pc),
        .if_id_imm_flag(w_imm_flag), .if_id_opcode(w_opcode),
        .if_id_rs(w_rs), .if_id_rd(w_rd), .if_id_shmnt(w_shmnt),
        .if_id_imm(w_imm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full IF/ID snapshot check against hand-computed values
    task automatic chk_ifid(input string tag, input logic v, input logic [4:0] op,
                            input logic [2:0] rs, input logic [2:0] rd, input logic [4:0] sh,
                            input logic [31:0] pc, input logic [31:0] npc,
                            input logic fl, input logic [15:0] imm);
        chk({tag, ".valid"},    32'(if_id_valid),    32'(v));
        chk({tag, ".opcode"},   32'(if_id_opcode),   32'(op));
        chk({tag, ".rs"},       32'(if_id_rs),       32'(rs));
        chk({tag, ".rd"},       32'(if_id_rd),       32'(rd));
        chk({tag, ".shmnt"},    32'(if_id_shmnt),    32'(sh));
        chk({tag, ".pc"},       if_id_pc,            pc);
        chk({tag, ".next_pc"},  if_id_next_pc,       npc);
        chk({tag, ".imm_flag"}, 32'(if_id_imm_flag), 32'(fl));
        chk({tag, ".imm"},      32'(if_id_imm),      32'(imm));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++)  mem2[i] = 16'h0000;
        mem[0]     = 16'h0823;  // op 1, rs 0, rd 1, sh 3
        mem[1]     = 16'h1000;  // op 2
        mem[2]     = 16'h8000;  // op 0x10, two-word
        mem[3]     = 16'hBEEF;
        mem[4]     = 16'h2000;  // op 4
        mem[5]     = 16'h2800;  // op 5
        mem[6]     = 16'h8123;  // op 0x10, rs 1, rd 1, sh 3, two-word
        mem[7]     = 16'h1234;
        mem[9'h40] = 16'h3000;  // op 6
        mem[9'h100] = 16'h48A7; // op 9, rs 0, rd 5, sh 7
        mem[9'h101] = 16'h8000;
        mem2[15]   = 16'h0823;

        rst = 1'b1; stall = 1'b0; jump_en = 1'b0; int_en = 1'b0;
        jump_addr = '0; int_addr = '0;
        w_jump_en = 1'b0; w_jump_addr = '0; w_int_addr = '0;

        step(); step();
        rst = 1'b0;
        chk("rst.imem_addr", imem_addr, 32'h0);
        chk_ifid("rst", 1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b0, 16'h0);

        step();
        chk_ifid("w0", 1'b1, 5'd1, 3'd0, 3'd1, 5'd3, 32'h0, 32'h1, 1'b0, 16'h0);
        chk("w0.imem_addr", imem_addr, 32'h1);

        step();
        chk_ifid("w1", 1'b1, 5'd2, 3'd0, 3'd0, 5'd0, 32'h1, 32'h2, 1'b0, 16'h0);

        step();
        chk("imm_first.valid", 32'(if_id_valid), 32'h0);
        chk("imm_first.imem_addr", imem_addr, 32'h3);

        step();
        chk_ifid("imm2", 1'b1, 5'h10, 3'd0, 3'd0, 5'd0, 32'h2, 32'h4, 1'b1, 16'hBEEF);
        chk("imm2.imem_addr", imem_addr, 32'h4);

        step();
        chk_ifid("w4", 1'b1, 5'd4, 3'd0, 3'd0, 5'd0, 32'h4, 32'h5, 1'b0, 16'h0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.imem_addr", imem_addr, 32'h5);
            chk_ifid("stall", 1'b1, 5'd4, 3'd0, 3'd0, 5'd0, 32'h4, 32'h5, 1'b0, 16'h0);
        end
        stall = 1'b0;

        step();
        chk_ifid("resume", 1'b1, 5'd5, 3'd0, 3'd0, 5'd0, 32'h5, 32'h6, 1'b0, 16'h0);

        step();
        chk("simm.valid", 32'(if_id_valid), 32'h0);
        chk("simm.imem_addr", imem_addr, 32'h7);

        jump_en = 1'b1; jump_addr = 32'h40;
        step();
        jump_en = 1'b0;
        chk("jump.valid", 32'(if_id_valid), 32'h0);
        chk("jump.imem_addr", imem_addr, 32'h40);

        step();
        chk_ifid("postjump", 1'b1, 5'd6, 3'd0, 3'd0, 5'd0, 32'h40, 32'h41, 1'b0, 16'h0);

        int_en = 1'b1; int_addr = 32'h100; jump_en = 1'b1; stall = 1'b1;
        step();
        int_en = 1'b0; jump_en = 1'b0; stall = 1'b0;
        chk("int.imem_addr", imem_addr, 32'h100);
        chk("int.valid", 32'(if_id_valid), 32'h0);

        step();
        chk_ifid("postint", 1'b1, 5'd9, 3'd0, 3'd5, 5'd7, 32'h100, 32'h101, 1'b0, 16'h0);

        step();
        chk("rstimm.valid", 32'(if_id_valid), 32'h0);
        chk("rstimm.imem_addr", imem_addr, 32'h102);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.imem_addr", imem_addr, 32'h0);
        chk_ifid("midrst", 1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b0, 16'h0);
        step();
        chk_ifid("afterrst", 1'b1, 5'd1, 3'd0, 3'd1, 5'd3, 32'h0, 32'h1, 1'b0, 16'h0);

        w_jump_en = 1'b1; w_jump_addr = 4'hF;
        step();
        w_jump_en = 1'b0;
        chk("wrap.jump_addr", 32'(w_imem_addr), 32'hF);
        step();
        chk("wrap.imem_addr", 32'(w_imem_addr), 32'h0);
        chk("wrap.valid", 32'(w_valid), 32'h1);
        chk("wrap.pc", 32'(w_pc), 32'hF);
        chk("wrap.next_pc", 32'(w_next_pc), 32'h0);
        chk("wrap.opcode", 32'(w_opcode), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
